irq_request_issuer: RTL and testbench
=====================================

Name: irq_request_issuer

Overview:
- Producer side of the four-channel interrupt routing interface.
- Collects requests and 8-bit payloads from four sources: a, b, c and d.
- Holds each request as pending, then issues one grant at a time as a one-hot 4-bit interrupt vector plus the matching payload, which feeds the interrupt decoder.
- Grants are held stable until the consumer acknowledges them or a timeout fires.

Parameters:
- TIMEOUT, 16: cycles a grant may wait for irq_ack_i before it is abandoned. Must be ≥ 2. 0 disables the timeout.
- RR_EN, 0: arbitration mode. 0 = fixed priority a>b>c>d. 1 = round-robin starting after the last granted channel.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- req_i  input  4  per-channel request strobe; bit3=a, bit2=b, bit1=c, bit0=d
- a_i, b_i, c_i, d_i  input  8 each  payloads, sampled when the matching req_i bit is high
- irq_ack_i  input  1  consumer acknowledge of the current grant
- ovf_clr_i  input  1  clears overflow_o
- interrupt_o  output  4  one-hot grant vector, same bit mapping as req_i; 0 when idle
- irq_valid_o  output  1  high while a grant is presented
- a_o, b_o, c_o, d_o  output  8 each  payload of the granted channel on its own lane; all other lanes 0
- pending_o  output  4  per-channel pending flags
- overflow_o  output  4  sticky per-channel dropped-request flags
- timeout_o  output  1  one-cycle pulse when a grant is abandoned

Behaviour:
- Reset (async assert, sync release):
  - interrupt_o=0, irq_valid_o=0, all payload outputs=0, pending_o=0, overflow_o=0, timeout_o=0.
  - State = IDLE, round-robin pointer = channel a, timeout counter = 0.
  - Reset mid-grant drops the grant and all pending requests immediately.
- Capture, per channel k:
  - req_i[k]=1 and pending[k]=0: store payload, set pending[k] at the next edge.
  - req_i[k]=1 and pending[k]=1, with k not being retired this cycle: discard the new payload, keep the old one, set overflow_o[k].
  - req_i[k]=1 in the same cycle channel k's grant retires by ack: capture the new payload, pending[k] stays 1.
- overflow_o[k] stays set until ovf_clr_i=1. If a new overflow and ovf_clr_i occur in the same cycle, the set wins.
- State IDLE:
  - If pending≠0, select a channel and register interrupt_o = one-hot(sel), the payload on lane sel, irq_valid_o=1; go to ISSUE.
  - Otherwise all outputs stay 0.
  - Selection with RR_EN=0: highest set bit of pending.
  - Selection with RR_EN=1: first set bit scanning downward (wrapping d→a) starting from the channel after the last granted one.
- State ISSUE:
  - interrupt_o, the payload outputs and irq_valid_o are held constant.
  - Exactly one interrupt_o bit is set whenever irq_valid_o=1; interrupt_o=0 whenever irq_valid_o=0.
  - The timeout counter increments each cycle.
  - irq_ack_i=1: clear pending[sel] (unless recaptured), update the round-robin pointer to sel, drive all outputs to 0 at the next edge, go to IDLE.
  - No ack and the counter reaches TIMEOUT−1: drop the grant, pulse timeout_o, leave pending[sel] set, update the round-robin pointer, go to IDLE.
  - If ack and timeout coincide, the ack wins and no timeout pulse is produced.
- irq_ack_i in IDLE is ignored.
- Latency:
  - A request arriving while idle with nothing pending: req_i at edge n, pending at n+1, grant visible after edge n+2.
  - Back-to-back grants: at least one cycle with interrupt_o=0 between them, so consecutive grants are ack at edge m, next grant after edge m+2.

Test Plan:
- Single request: req_i=4'b0100, b_i=8'h5A at cycle 0 → cycle 2: interrupt_o=4'b0100, b_o=8'h5A, all other lanes 0, valid=1. Ack at cycle 4 → cycle 5: all outputs 0, pending_o=0.
- Fixed priority (RR_EN=0): req_i=4'b1111 with payloads 11/22/33/44 → grants in order a, b, c, d. Each is separated by one zero cycle and carries the correct payload.
- Round-robin (RR_EN=1): keep a and c permanently re-requested → grants alternate a, c, a, c. Channel a never takes two consecutive grants.
- Overflow: req d with 8'h01, then req d with 8'h02 before any grant → overflow_o=4'b0001 and the granted payload is 8'h01. Pulse ovf_clr_i → overflow_o=0.
- Timeout (TIMEOUT=4): grant c and withhold the ack → after 4 ISSUE cycles: timeout_o pulses once, valid drops, pending_o[1] remains 1, and c is re-granted 2 cycles later.
- Asynchronous reset mid-grant: assert rst_i while interrupt_o=4'b1000 → all outputs 0 immediately. After release, nothing is issued until a new request arrives.

Source files
------------

// File: rtl/irq_request_issuer.sv
// Four-channel interrupt request issuer. Each channel captures requests and payloads.
// One grant at a time is then presented until it is acknowledged or it times out.
module irq_lane (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       req,
   input  logic [7:0] din,
   input  logic       retire,
   input  logic       ovf_clr,
   output logic       pending,
   output logic [7:0] payload,
   output logic       ovf
);
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending <= 1'b0;
         payload <= '0;
         ovf     <= 1'b0;
      end else begin
         // A retiring slot is free again, so a request in that same cycle refills it.
         if (req && (!pending || retire)) begin
            pending <= 1'b1;
            payload <= din;
         end else if (retire) begin
            pending <= 1'b0;
         end
         if (req && pending && !retire) ovf <= 1'b1;
         else if (ovf_clr)              ovf <= 1'b0;
      end
   end
endmodule

module irq_request_issuer #(
   parameter int TIMEOUT = 16,
   parameter int RR_EN   = 0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] req_i,
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic [7:0] c_i,
   input  logic [7:0] d_i,
   input  logic       irq_ack_i,
   input  logic       ovf_clr_i,
   output logic [3:0] interrupt_o,
   output logic       irq_valid_o,
   output logic [7:0] a_o,
   output logic [7:0] b_o,
   output logic [7:0] c_o,
   output logic [7:0] d_o,
   output logic [3:0] pending_o,
   output logic [3:0] overflow_o,
   output logic       timeout_o
);
   localparam int N     = 4;
   localparam int CW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam bit TO_EN = (TIMEOUT != 0);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t              state;
   logic [N-1:0][7:0]   din, pay, dout;
   logic [N-1:0]        pend, ovf, retire;
   logic [1:0]          sel_q, sel_nxt, rr_ptr, idx;
   logic [CW-1:0]       cnt;

   assign din         = {a_i, b_i, c_i, d_i};
   assign {a_o, b_o, c_o, d_o} = dout;
   assign pending_o   = pend;
   assign overflow_o  = ovf;
   assign retire      = (state == ISSUE && irq_ack_i) ? (N'(1) << sel_q) : '0;

   for (genvar k = 0; k < N; k++) begin : g_lane
      irq_lane u_lane (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .req     (req_i[k]),
         .din     (din[k]),
         .retire  (retire[k]),
         .ovf_clr (ovf_clr_i),
         .pending (pend[k]),
         .payload (pay[k]),
         .ovf     (ovf[k])
      );
   end

   // Later loop iterations override earlier ones: highest bit wins in fixed mode,
   // and in round-robin mode the channel just below rr_ptr wins.
   always_comb begin
      sel_nxt = '0;
      idx     = '0;
      if (RR_EN != 0) begin
         for (int i = N; i >= 1; i--) begin
            idx = rr_ptr - 2'(i);
            if (pend[idx]) sel_nxt = idx;
         end
      end else begin
         for (int i = 0; i < N; i++)
            if (pend[i]) sel_nxt = 2'(i);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         sel_q       <= '0;
         rr_ptr      <= 2'd3;
         cnt         <= '0;
         interrupt_o <= '0;
         irq_valid_o <= 1'b0;
         dout        <= '0;
         timeout_o   <= 1'b0;
      end else begin
         timeout_o <= 1'b0;
         case (state)
            IDLE: if (|pend) begin
               sel_q          <= sel_nxt;
               interrupt_o    <= N'(1) << sel_nxt;
               irq_valid_o    <= 1'b1;
               dout           <= '0;
               dout[sel_nxt]  <= pay[sel_nxt];
               cnt            <= '0;
               state          <= ISSUE;
            end
            ISSUE: begin
               if (irq_ack_i || (TO_EN && cnt == CW'(TIMEOUT - 1))) begin
                  timeout_o   <= !irq_ack_i;
                  rr_ptr      <= sel_q;
                  interrupt_o <= '0;
                  irq_valid_o <= 1'b0;
                  dout        <= '0;
                  cnt         <= '0;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_irq_request_issuer.sv
// Directed bench: dut0 runs fixed priority, dut1 round-robin, both with TIMEOUT=4 and shared inputs.
module tb_irq_request_issuer;
   logic       clk = 1'b0, rst = 1'b1;
   logic [3:0] req = '0;
   logic [7:0] a_i = '0, b_i = '0, c_i = '0, d_i = '0;
   logic       ack = 1'b0, ovf_clr = 1'b0;

   logic [3:0] irq0, pend0, ovf0, irq1, pend1, ovf1;
   logic       v0, to0, v1, to1;
   logic [7:0] a0, b0, c0, d0, a1, b1, c1, d1;
   logic [3:0] prev;

   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   irq_request_issuer #(.TIMEOUT(4), .RR_EN(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .a_i(a_i), .b_i(b_i), .c_i(c_i), .d_i(d_i),
      .irq_ack_i(ack), .ovf_clr_i(ovf_clr), .interrupt_o(irq0), .irq_valid_o(v0),
      .a_o(a0), .b_o(b0), .c_o(c0), .d_o(d0), .pending_o(pend0), .overflow_o(ovf0),
      .timeout_o(to0));

   irq_request_issuer #(.TIMEOUT(4), .RR_EN(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .a_i(a_i), .b_i(b_i), .c_i(c_i), .d_i(d_i),
      .irq_ack_i(ack), .ovf_clr_i(ovf_clr), .interrupt_o(irq1), .irq_valid_o(v1),
      .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .pending_o(pend1), .overflow_o(ovf1),
      .timeout_o(to1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] pays [4];
      pays[3] = 8'h11; pays[2] = 8'h22; pays[1] = 8'h33; pays[0] = 8'h44;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_irq", {irq0, irq1}, 8'h00);
      chk("rst_valid", {v0, v1, to0, to1}, 4'b0000);
      chk("rst_lanes", {a0, b0, c0, d0}, 32'h0);
      chk("rst_pend_ovf", {pend0, ovf0}, 8'h00);
      rst = 1'b0;

      // single request on b
      req = 4'b0100; b_i = 8'h5A;
      tick(); req = '0;
      chk("single_pend", pend0, 4'b0100);
      chk("single_idle", irq0, 4'b0000);
      tick();
      chk("single_irq", irq0, 4'b0100);
      chk("single_lanes", {a0, b0, c0, d0}, 32'h005A_0000);
      chk("single_valid", v0, 1'b1);
      tick();
      chk("single_hold", {irq0, b0}, {4'b0100, 8'h5A});
      tick(); ack = 1'b1;
      tick(); ack = 1'b0;
      chk("single_done", {irq0, v0, pend0}, 9'h0);
      chk("single_lanes0", {a0, b0, c0, d0}, 32'h0);

      // fixed priority a>b>c>d, each grant followed by one zero cycle
      req = 4'b1111; a_i = 8'h11; b_i = 8'h22; c_i = 8'h33; d_i = 8'h44;
      tick(); req = '0;
      for (int k = 3; k >= 0; k--) begin
         tick();
         chk("fp_irq", irq0, 32'(1) << k);
         chk("fp_lanes", {a0, b0, c0, d0}, 32'(pays[k]) << (8 * k));
         ack = 1'b1;
         tick(); ack = 1'b0;
         chk("fp_gap", {irq0, v0}, 5'h0);
      end
      chk("fp_pend", pend0, 4'b0000);

      // overflow: second request on d while pending keeps the first payload
      req = 4'b0001; d_i = 8'h01;
      tick(); d_i = 8'h02;
      tick(); req = '0;
      chk("ovf_flag", ovf0, 4'b0001);
      chk("ovf_irq", irq0, 4'b0001);
      chk("ovf_payload", d0, 8'h01);
      ack = 1'b1;
      tick(); ack = 1'b0;
      chk("ovf_sticky", {ovf0, pend0}, {4'b0001, 4'b0000});
      ovf_clr = 1'b1;
      tick(); ovf_clr = 1'b0;
      chk("ovf_clr", ovf0, 4'b0000);

      // timeout after 4 unacknowledged ISSUE cycles, then re-grant of c
      req = 4'b0010; c_i = 8'h77;
      tick(); req = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("to_hold", {irq0, v0, to0, c0}, {4'b0010, 1'b1, 1'b0, 8'h77});
      end
      tick();
      chk("to_pulse", {irq0, v0, to0}, {4'b0000, 1'b0, 1'b1});
      chk("to_pend", pend0, 4'b0010);
      tick();
      chk("to_regrant", {irq0, v0, to0, c0}, {4'b0010, 1'b1, 1'b0, 8'h77});
      ack = 1'b1;
      tick(); ack = 1'b0;
      chk("to_cleared", {pend0, to0}, 5'h0);

      // async reset mid-grant
      req = 4'b1000; a_i = 8'hAA;
      tick(); req = '0;
      tick();
      chk("ar_grant", irq0, 4'b1000);
      #2 rst = 1'b1;
      #1;
      chk("ar_immediate", {irq0, v0, a0, pend0}, 17'h0);
      tick(); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ar_quiet", {irq0, v0, pend0}, 9'h0);
      end

      // round-robin with a and c permanently re-requested
      req = 4'b1010; a_i = 8'hA1; c_i = 8'hC1;
      prev = '0;
      for (int g = 0; g < 6; g++) begin
         for (int w = 0; w < 5 && !v1; w++) tick();
         chk("rr_valid", v1, 1'b1);
         chk("rr_onehot", (irq1 == 4'b1000 || irq1 == 4'b0010), 1'b1);
         chk("rr_payload", {a1, c1}, (irq1 == 4'b1000) ? 16'hA100 : 16'h00C1);
         if (g > 0) chk("rr_alternate", (irq1 != prev), 1'b1);
         prev = irq1;
         ack = 1'b1;
         tick(); ack = 1'b0;
      end
      req = '0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
